meas_cmd_sched: RTL

//  Queues parsed 112-bit measurement commands from the UART receive path and issues them one at a time to the

---
 rtl/meas_pkg.sv | 17 +
 rtl/cmd_fifo.sv | 39 +++
 rtl/meas_cmd_sched.sv | 90 +++++++++
 3 files changed

// File: rtl/meas_pkg.sv
// meas_pkg: shared command layout and scheduler state encoding for the measurement command path.
package meas_pkg;
    localparam int CMD_W  = 112;
    localparam int REP_HI = 111;
    localparam int REP_LO = 109;
    localparam int DA2_HI = 108;
    localparam int DA2_LO = 96;
    localparam int SW_HI  = 88;
    localparam int SW_LO  = 80;
    localparam int ADC_HI = 79;
    localparam int ADC_LO = 48;
    localparam int DA1_HI = 44;
    localparam int DA1_LO = 32;
    localparam int WID_HI = 31;
    localparam int WID_LO = 0;
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAP} state_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous first-word-fall-through command queue with full/empty flags and occupancy count.
module cmd_fifo
    import meas_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CMD_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [CMD_W-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_comb begin
        head  = mem[rd_ptr];
        full  = count == (AW+1)'(DEPTH);
        empty = count == '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
endmodule

// File: rtl/meas_cmd_sched.sv
// meas_cmd_sched: queues measurement commands and issues them to the pulse/ADC engine with
// repeats, settle gap, done-wait timeout and sticky status.
module meas_cmd_sched
    import meas_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int GAP_CYC     = 1000,
    parameter int TIMEOUT_CYC = 2**28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] cmd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [CMD_W-1:0] eng_cmd,
    output logic             eng_start,
    input  logic             eng_done,
    output logic             eng_abort,
    output logic             busy,
    output logic             err_ovf,
    output logic             err_tmo,
    input  logic             err_clr,
    output logic [15:0]      run_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);
    state_t state, nstate;
    logic [CMD_W-1:0] head;
    logic full, empty, push, pop, done_w, tmo, gap_end;
    logic [$clog2(DEPTH):0] q_cnt;
    logic [TW-1:0] timer;
    logic [GW-1:0] gap_cnt;
    logic [2:0] rep_left;
    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .wr_en(push), .wr_data(cmd_data), .rd_en(pop),
        .head(head), .full(full), .empty(empty), .count(q_cnt)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end
    always_comb begin
        pop       = state == LOAD;
        push      = cmd_valid && (!full || pop);
        done_w    = state == WAIT && eng_done;
        tmo       = state == WAIT && !eng_done && timer == T_LAST;
        gap_end   = state == GAP && gap_cnt == G_LAST;
        eng_start = state == START;
        eng_abort = tmo;
        cmd_ready = !full;
        busy      = state != IDLE || q_cnt != '0;
        nstate    = state;
        unique case (state)
            IDLE:    nstate = empty ? IDLE : LOAD;
            LOAD:    nstate = START;
            START:   nstate = WAIT;
            WAIT:    nstate = (done_w || tmo) ? GAP : WAIT;
            GAP:     nstate = !gap_end ? GAP : rep_left != '0 ? START : !empty ? LOAD : IDLE;
            default: nstate = IDLE;
        endcase
    end
    // Timers self-clear outside their state, so START clears the timeout timer implicitly.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_cmd  <= '0;
            rep_left <= '0;
            timer    <= '0;
            gap_cnt  <= '0;
            run_cnt  <= '0;
            err_ovf  <= 1'b0;
            err_tmo  <= 1'b0;
        end else begin
            if (pop) begin
                eng_cmd  <= head;
                rep_left <= head[REP_HI:REP_LO];
            end else if (tmo) begin
                rep_left <= '0;
            end else if (gap_end && rep_left != '0) begin
                rep_left <= rep_left - 1'b1;
            end
            timer   <= state == WAIT ? timer + 1'b1 : '0;
            gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
            if (done_w) run_cnt <= run_cnt + 1'b1;
            err_ovf <= (cmd_valid && !push) || (err_ovf && !err_clr);
            err_tmo <= tmo || (err_tmo && !err_clr);
        end
    end
endmodule
